v850_regfile: RTL and testbench



---
 rtl/v850_regfile.sv | 82 ++++++++
 tb/tb_v850_regfile.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/v850_regfile.sv
// v850_regfile: V850 GPR file with NUM_RD registered read ports, two prioritised write ports and a busy scoreboard.
// Optional same-edge write-to-read forwarding is enabled by defining V850_REGFILE_BYPASS_EN.
module v850_regfile #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);
  logic [DATA_W-1:0]   rf_q [NUM_REGS-1];
  logic [DATA_W-1:0]   rf_v [NUM_REGS];
  logic [NUM_REGS-1:1] busy_q, busy_d;
  logic                w0_ok, w1_ok;
  assign w0_ok = wr0_en && wr0_addr != '0;
  assign w1_ok = wr1_en && wr1_addr != '0;
  assign busy_vec = {busy_q, 1'b0};
  // r0 has no storage; the read view supplies the hardwired zero
  always_comb begin
    rf_v[0] = '0;
    for (int n = 1; n < NUM_REGS; n++) rf_v[n] = rf_q[n-1];
  end
  // a new issue supersedes a completing write to the same register
  always_comb begin
    busy_d = busy_q;
    for (int n = 1; n < NUM_REGS; n++)
      busy_d[n] = (iss_en && iss_addr == ADDR_W'(n)) ? 1'b1 :
                  ((w0_ok && wr0_addr == ADDR_W'(n)) || (w1_ok && wr1_addr == ADDR_W'(n))) ? 1'b0 :
                  busy_q[n];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int n = 0; n < NUM_REGS - 1; n++) rf_q[n] <= '0;
    end else begin
      busy_q <= busy_d;
      for (int n = 1; n < NUM_REGS; n++)
        if (w0_ok && wr0_addr == ADDR_W'(n)) rf_q[n-1] <= wr0_data;
        else if (w1_ok && wr1_addr == ADDR_W'(n)) rf_q[n-1] <= wr1_data;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1, busy_d_r, busy_q_r;
    logic [DATA_W-1:0] data_d, data_q;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
`ifdef V850_REGFILE_BYPASS_EN
    assign hit0 = w0_ok && wr0_addr == ra;
    assign hit1 = w1_ok && wr1_addr == ra;
`else
    assign hit0 = 1'b0;
    assign hit1 = 1'b0;
`endif
    assign data_d = rd_en[i] ? (hit0 ? wr0_data : hit1 ? wr1_data : rf_v[ra]) : data_q;
    assign busy_d_r = rd_en[i] ? (busy_vec[ra] && !(hit0 || hit1)) : busy_q_r;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        busy_q_r <= 1'b0;
      end else begin
        data_q <= data_d;
        busy_q_r <= busy_d_r;
      end
    end
    assign rd_data[i*DATA_W +: DATA_W] = data_q;
    assign rd_busy[i] = busy_q_r;
  end
endmodule

// File: tb/tb_v850_regfile.sv
// tb_v850_regfile: directed and randomised checks of v850_regfile against a behavioural array model.
module tb_v850_regfile;
  localparam int DW = 32, NR = 32, AW = 5, NRD = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NRD-1:0] rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic wr0_en, wr1_en, iss_en;
  logic [AW-1:0] wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic [NR-1:0] busy_vec;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] m_reg [NR] = '{default: '0};
  logic m_busy [NR] = '{default: 1'b0};
  logic [DW-1:0] m_rd [NRD] = '{default: '0};
  logic m_rb [NRD] = '{default: 1'b0};
  logic [AW-1:0] ma;
  logic [NR-1:0] mbv;

  v850_regfile #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_vec(busy_vec));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: reads see pre-edge state (plus forwarding when enabled), then writes, then issue.
  always @(posedge clk) if (rst_n) begin
    for (int i = 0; i < NRD; i++) if (rd_en[i]) begin
      ma = rd_addr[i*AW +: AW];
      m_rd[i] = (ma == 0) ? '0 : m_reg[ma];
      m_rb[i] = m_busy[ma];
`ifdef V850_REGFILE_BYPASS_EN
      if (ma != 0 && wr0_en && wr0_addr == ma) begin m_rd[i] = wr0_data; m_rb[i] = 1'b0; end
      else if (ma != 0 && wr1_en && wr1_addr == ma) begin m_rd[i] = wr1_data; m_rb[i] = 1'b0; end
`endif
    end
    if (wr1_en && wr1_addr != 0) begin m_reg[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
    if (wr0_en && wr0_addr != 0) begin m_reg[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
  end

  always @(negedge rst_n) begin
    for (int n = 0; n < NR; n++) begin m_reg[n] = '0; m_busy[n] = 1'b0; end
    for (int i = 0; i < NRD; i++) begin m_rd[i] = '0; m_rb[i] = 1'b0; end
  end

  always @(negedge clk) begin
    for (int n = 0; n < NR; n++) mbv[n] = m_busy[n];
    for (int i = 0; i < NRD; i++) begin
      chk($sformatf("model rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(m_rd[i]));
      chk($sformatf("model rd_busy%0d", i), 64'(rd_busy[i]), 64'(m_rb[i]));
    end
    chk("model busy_vec", 64'(busy_vec), 64'(mbv));
  end

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr0_en = 0; wr1_en = 0; iss_en = 0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0; wr0_data = '0; wr1_data = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input int p, input logic [AW-1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
  endtask
  task automatic w0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr0_en = 1; wr0_addr = a; wr0_data = d;
  endtask
  task automatic w1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr1_en = 1; wr1_addr = a; wr1_data = d;
  endtask
  task automatic iss(input logic [AW-1:0] a);
    iss_en = 1; iss_addr = a;
  endtask

  initial begin
    idle();
    w0(5, 32'hDEAD_BEEF); iss(5); rd(0, 5); rd(1, 5);
    tick(); tick();
    chk("reset rd_data", 64'(rd_data), 64'h0);
    chk("reset rd_busy", 64'(rd_busy), 64'h0);
    chk("reset busy_vec", 64'(busy_vec), 64'h0);
    rst_n = 1'b1;
    idle(); rd(0, 5); tick();
    chk("r5 after reset", 64'(rd_data[31:0]), 64'h0);
    idle(); w0(3, 32'h1234_5678); tick();
    idle(); rd(1, 3); tick();
    chk("r3 port1", 64'(rd_data[63:32]), 64'h1234_5678);
    idle(); w0(0, 32'hFFFF_FFFF); tick();
    idle(); rd(0, 0); rd(1, 0); tick();
    chk("r0 reads zero", 64'(rd_data), 64'h0);
    idle(); w0(7, 32'hAAAA_0000); w1(7, 32'h5555_0000); tick();
    idle(); rd(0, 7); tick();
    chk("collision wr0 wins", 64'(rd_data[31:0]), 64'hAAAA_0000);
    idle(); iss(9); tick();
    chk("issue r9 busy", 64'(busy_vec), 64'h200);
    idle(); rd(1, 9); tick();
    chk("rd_busy r9", 64'(rd_busy[1]), 64'h1);
    idle(); w1(9, 32'h42); tick();
    chk("wr1 clears r9", 64'(busy_vec), 64'h0);
    idle(); iss(9); w0(9, 32'h77); tick();
    chk("issue+write busy", 64'(busy_vec), 64'h200);
    idle(); rd(0, 9); tick();
    chk("r9 value", 64'(rd_data[31:0]), 64'h77);
    chk("r9 rd_busy", 64'(rd_busy[0]), 64'h1);
    idle(); w0(4, 32'h11); iss(4); tick();
    idle(); w0(4, 32'h22); rd(0, 4); tick();
`ifdef V850_REGFILE_BYPASS_EN
    chk("bypass data", 64'(rd_data[31:0]), 64'h22);
    chk("bypass busy", 64'(rd_busy[0]), 64'h0);
`else
    chk("no-bypass data", 64'(rd_data[31:0]), 64'h11);
    chk("no-bypass busy", 64'(rd_busy[0]), 64'h1);
`endif
    chk("r4 cleared", 64'(busy_vec[4]), 64'h0);
    idle(); w0(31, 32'hCAFE_F00D); w1(30, 32'h0BAD_0001); tick();
    idle(); rd(0, 31); rd(1, 30); tick();
    chk("top reg port0", 64'(rd_data[31:0]), 64'hCAFE_F00D);
    chk("dual write port1", 64'(rd_data[63:32]), 64'h0BAD_0001);
    for (int k = 0; k < 80; k++) begin
      idle();
      wr0_en = 1'($urandom); wr0_addr = AW'($urandom_range(0, 7)); wr0_data = $urandom;
      wr1_en = 1'($urandom); wr1_addr = AW'($urandom_range(0, 7)); wr1_data = $urandom;
      iss_en = 1'($urandom); iss_addr = AW'($urandom_range(0, 7));
      rd_en = NRD'($urandom_range(0, 3));
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      tick();
    end
    idle(); w0(2, 32'h99); tick();
    idle(); iss(2); tick();
    idle(); iss(3); rd(0, 2); rd(1, 3); tick();
    chk("pre-reset busy", 64'(busy_vec & 32'hC), 64'hC);
    chk("pre-reset r2", 64'(rd_data[31:0]), 64'h99);
    idle(); #2 rst_n = 1'b0; #1;
    chk("async rd_data", 64'(rd_data), 64'h0);
    chk("async rd_busy", 64'(rd_busy), 64'h0);
    chk("async busy_vec", 64'(busy_vec), 64'h0);
    tick(); rst_n = 1'b1;
    idle(); rd(0, 2); tick();
    chk("r2 after reset", 64'(rd_data[31:0]), 64'h0);
    idle(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
